// File: rtl/rsqrt_seq.sv
// rsqrt_seq: sequences Newton-Raphson refinement of the magic-constant
// reciprocal-square-root seed on an external shared FMA (a*b+c).
// Optional build macro: RSQRT_SQRT_OUT_EN adds a final x*y step so the
// block returns sqrt(x) instead of 1/sqrt(x), with matching special cases.
module rsqrt_seq #(
  parameter int BUS_WIDTH = 64,
  parameter int NR_ITERS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_y,
  output logic                 out_nv,
  output logic                 out_dz,
  output logic                 fma_req,
  output logic [BUS_WIDTH-1:0] fma_a,
  output logic [BUS_WIDTH-1:0] fma_b,
  output logic [BUS_WIDTH-1:0] fma_c,
  input  logic                 fma_ack,
  input  logic [BUS_WIDTH-1:0] fma_res,
  output logic                 busy
);
  localparam int W     = BUS_WIDTH;
  localparam int EXP_W = (W == 32) ? 8 : 11;
  localparam int MAN_W = W - 1 - EXP_W;

  localparam logic [63:0] MAGIC_64 = (W == 32) ? 64'h0000_0000_5F37_59DF : 64'h5FE6_EB50_C7B5_37A9;
  localparam logic [63:0] HALF3_64 = (W == 32) ? 64'h0000_0000_3FC0_0000 : 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] NHALF_64 = (W == 32) ? 64'h0000_0000_BF00_0000 : 64'hBFE0_0000_0000_0000;
  localparam logic [63:0] QNAN_64  = (W == 32) ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;

  localparam logic [W-1:0] MAGIC      = MAGIC_64[W-1:0];
  localparam logic [W-1:0] THREE_HALF = HALF3_64[W-1:0];
  localparam logic [W-1:0] NEG_HALF   = NHALF_64[W-1:0];
  localparam logic [W-1:0] QNAN       = QNAN_64[W-1:0];
  localparam logic [W-1:0] POS_INF    = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALF  = 3'd1,
    S_SQ    = 3'd2,
    S_MADD  = 3'd3,
    S_MUL   = 3'd4,
`ifdef RSQRT_SQRT_OUT_EN
    S_FINAL = 3'd5,
`endif
    S_DONE  = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   xh_q, xh_d;
  logic [W-1:0]   t_q, t_d;
  logic [2:0]     iter_q, iter_d;
  logic [2:0]     iter_inc;
  logic           nv_q, nv_d;
  logic           dz_q, dz_d;

  // Operand field decode used for special-class bypass at accept.
  logic             sign_in;
  logic [EXP_W-1:0] exp_in;
  logic [MAN_W-1:0] man_in;
  assign sign_in = in_x[W-1];
  assign exp_in  = in_x[W-2:MAN_W];
  assign man_in  = in_x[MAN_W-1:0];

  // State and datapath registers; reset returns everything to an idle, zeroed block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xh_q    <= '0;
      t_q     <= '0;
      iter_q  <= '0;
      nv_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xh_q    <= xh_d;
      t_q     <= t_d;
      iter_q  <= iter_d;
      nv_q    <= nv_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state logic and FMA operand selection; operands are zero unless requesting.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    xh_d     = xh_q;
    t_d      = t_q;
    iter_d   = iter_q;
    nv_d     = nv_q;
    dz_d     = dz_q;
    fma_req  = 1'b0;
    fma_a    = '0;
    fma_b    = '0;
    fma_c    = '0;
    iter_inc = iter_q + 3'd1;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = MAGIC - (in_x >> 1);
          iter_d  = '0;
          nv_d    = 1'b0;
          dz_d    = 1'b0;
          state_d = S_HALF;
          if (exp_in == '0) begin
            // Zero and subnormals (flushed) keep their sign.
            state_d = S_DONE;
`ifdef RSQRT_SQRT_OUT_EN
            y_d     = {sign_in, {(W-1){1'b0}}};
`else
            y_d     = {sign_in, POS_INF[W-2:0]};
            dz_d    = 1'b1;
`endif
          end else if (((&exp_in) && (man_in != '0)) || sign_in) begin
            state_d = S_DONE;
            y_d     = QNAN;
            nv_d    = 1'b1;
          end else if (&exp_in) begin
            state_d = S_DONE;
`ifdef RSQRT_SQRT_OUT_EN
            y_d     = POS_INF;
`else
            y_d     = '0;
`endif
          end
        end
      end
      S_HALF: begin
        fma_req = 1'b1;
        fma_a   = x_q;
        fma_b   = NEG_HALF;
        if (fma_ack) begin
          xh_d    = fma_res;
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        fma_req = 1'b1;
        fma_a   = y_q;
        fma_b   = y_q;
        if (fma_ack) begin
          t_d     = fma_res;
          state_d = S_MADD;
        end
      end
      S_MADD: begin
        fma_req = 1'b1;
        fma_a   = xh_q;
        fma_b   = t_q;
        fma_c   = THREE_HALF;
        if (fma_ack) begin
          t_d     = fma_res;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        fma_req = 1'b1;
        fma_a   = y_q;
        fma_b   = t_q;
        if (fma_ack) begin
          y_d    = fma_res;
          iter_d = iter_inc;
`ifdef RSQRT_SQRT_OUT_EN
          state_d = (iter_inc < 3'(NR_ITERS)) ? S_SQ : S_FINAL;
`else
          state_d = (iter_inc < 3'(NR_ITERS)) ? S_SQ : S_DONE;
`endif
        end
      end
`ifdef RSQRT_SQRT_OUT_EN
      S_FINAL: begin
        fma_req = 1'b1;
        fma_a   = x_q;
        fma_b   = y_q;
        if (fma_ack) begin
          y_d     = fma_res;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_y     = out_valid ? y_q : '0;
  assign out_nv    = out_valid & nv_q;
  assign out_dz    = out_valid & dz_q;

endmodule

// File: tb/tb_rsqrt_seq.sv
// Bench for rsqrt_seq: a binary32 instance (NR_ITERS=2) and a binary64
// instance (NR_ITERS=4), each served by a behavioural FMA with selectable
// ack delay. Follows RSQRT_SQRT_OUT_EN for its expectations.
module tb_rsqrt_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv32 = 0, ir32, ov32, or32 = 0, nv32, dz32, req32, ack32 = 0, busy32;
  logic [31:0] x32 = 0, y32, a32, b32, c32, res32 = 0;
  logic        iv64 = 0, ir64, ov64, or64 = 0, nv64, dz64, req64, ack64 = 0, busy64;
  logic [63:0] x64 = 0, y64, a64, b64, c64, res64 = 0;

  rsqrt_seq #(.BUS_WIDTH(32), .NR_ITERS(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in_x(x32),
    .out_valid(ov32), .out_ready(or32), .out_y(y32), .out_nv(nv32), .out_dz(dz32),
    .fma_req(req32), .fma_a(a32), .fma_b(b32), .fma_c(c32), .fma_ack(ack32),
    .fma_res(res32), .busy(busy32));

  rsqrt_seq #(.BUS_WIDTH(64), .NR_ITERS(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .in_x(x64),
    .out_valid(ov64), .out_ready(or64), .out_y(y64), .out_nv(nv64), .out_dz(dz64),
    .fma_req(req64), .fma_a(a64), .fma_b(b64), .fma_c(c64), .fma_ack(ack64),
    .fma_res(res64), .busy(busy64));

`ifdef RSQRT_SQRT_OUT_EN
  localparam int EXTRA = 1;
  localparam logic [31:0] E_4 = 32'h40000000, E_16 = 32'h40800000, E_Q = 32'h3F000000;
  localparam logic [31:0] E_PZ = 32'h00000000, E_NZ = 32'h80000000, E_PINF = 32'h7F800000;
  localparam logic DZ = 1'b0;
  localparam real R64 = 1.4142135623730951;
`else
  localparam int EXTRA = 0;
  localparam logic [31:0] E_4 = 32'h3F000000, E_16 = 32'h3E800000, E_Q = 32'h40000000;
  localparam logic [31:0] E_PZ = 32'h7F800000, E_NZ = 32'hFF800000, E_PINF = 32'h00000000;
  localparam logic DZ = 1'b1;
  localparam real R64 = 0.7071067811865476;
`endif
  localparam int LAT32  = 2 + 3 * 2 + EXTRA;
  localparam int ACKS32 = 1 + 3 * 2 + EXTRA;
  localparam int ACKS64 = 1 + 3 * 4 + EXTRA;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_real(input string name, input real got, input real exp, input real tol);
    real rel;
    n_cmp++;
    rel = (got - exp) / exp;
    if (rel < 0.0) rel = -rel;
    if (!(rel <= tol)) begin
      n_bad++;
      $display("FAIL %s: got %g expected %g (rel err %g)", name, got, exp, rel);
    end
  endtask

  function automatic real f32_to_real(input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    e = {3'b000, b[30:23]} + 11'd896;
    if (b[30:23] == 8'd0) d = {b[31], 63'd0};
    else d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] <= 11'd896) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural FMA models: mode 0 zero-wait, 1 random 0..5 waits, 2 fixed 3 waits.
  int cnt32 = -1, mode32 = 0, acks32 = 0;
  bit en32 = 1'b1;
  logic [31:0] log_a [0:7];
  logic [31:0] log_b [0:7];
  logic [31:0] log_c [0:7];
  always @(negedge clk) begin
    if (en32) begin
      ack32 = 1'b0;
      if (req32) begin
        if (cnt32 < 0) cnt32 = (mode32 == 1) ? int'($urandom_range(5, 0)) : ((mode32 == 2) ? 3 : 0);
        if (cnt32 == 0) begin
          ack32 = 1'b1;
          res32 = real_to_f32(f32_to_real(a32) * f32_to_real(b32) + f32_to_real(c32));
          if (acks32 < 8) begin
            log_a[acks32] = a32;
            log_b[acks32] = b32;
            log_c[acks32] = c32;
          end
          acks32++;
          cnt32 = -1;
        end else cnt32--;
      end else cnt32 = -1;
    end else cnt32 = -1;
  end

  int cnt64 = -1, mode64 = 0, acks64 = 0;
  always @(negedge clk) begin
    ack64 = 1'b0;
    if (req64) begin
      if (cnt64 < 0) cnt64 = (mode64 == 1) ? int'($urandom_range(5, 0)) : 0;
      if (cnt64 == 0) begin
        ack64 = 1'b1;
        res64 = $realtobits($bitstoreal(a64) * $bitstoreal(b64) + $bitstoreal(c64));
        acks64++;
        cnt64 = -1;
      end else cnt64--;
    end else cnt64 = -1;
  end

  // One full transaction on the selected instance, with optional output backpressure.
  task automatic run_op(input bit w, input logic [63:0] x, input int hold,
                        output logic [63:0] y, output logic nv, output logic dz,
                        output int lat, output int acks);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(w ? ir64 : ir32) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", {63'd0, (w ? ir64 : ir32)}, 64'd1);
    if (w) begin iv64 = 1'b1; x64 = x; acks64 = 0; end
    else begin iv32 = 1'b1; x32 = x[31:0]; acks32 = 0; end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        iv32 = 1'b0; iv64 = 1'b0;
        x32 = $urandom; x64 = {$urandom, $urandom};
      end
    end while (!(w ? ov64 : ov32) && lat < 300);
    chk("done_seen", {63'd0, (w ? ov64 : ov32)}, 64'd1);
    y  = w ? y64 : {32'd0, y32};
    nv = w ? nv64 : nv32;
    dz = w ? dz64 : dz32;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("bp_y_c%0d", i), (w ? y64 : {32'd0, y32}), y);
      chk($sformatf("bp_in_ready_c%0d", i), {63'd0, (w ? ir64 : ir32)}, 64'd0);
    end
    if (w) or64 = 1'b1; else or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0; or64 = 1'b0;
    chk("in_ready_after_accept", {63'd0, (w ? ir64 : ir32)}, 64'd1);
    acks = w ? acks64 : acks32;
  endtask

  typedef struct packed {
    logic [31:0] x;
    logic        sp;
    logic [31:0] y;
    logic        nv;
    logic        dz;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [63:0] y;
    logic nv, dz;
    int lat, acks, guard;

    vecs[0]  = '{32'h40800000, 1'b0, E_4,          1'b0, 1'b0};
    vecs[1]  = '{32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[2]  = '{32'h41800000, 1'b0, E_16,         1'b0, 1'b0};
    vecs[3]  = '{32'h3E800000, 1'b0, E_Q,          1'b0, 1'b0};
    vecs[4]  = '{32'h00000000, 1'b1, E_PZ,         1'b0, DZ};
    vecs[5]  = '{32'h80000000, 1'b1, E_NZ,         1'b0, DZ};
    vecs[6]  = '{32'h00000001, 1'b1, E_PZ,         1'b0, DZ};
    vecs[7]  = '{32'h807FFFFF, 1'b1, E_NZ,         1'b0, DZ};
    vecs[8]  = '{32'hC0000000, 1'b1, 32'h7FC00000, 1'b1, 1'b0};
    vecs[9]  = '{32'h7F800000, 1'b1, E_PINF,       1'b0, 1'b0};
    vecs[10] = '{32'hFF800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0};
    vecs[11] = '{32'h7FC00001, 1'b1, 32'h7FC00000, 1'b1, 1'b0};
    vecs[12] = '{32'hFF800001, 1'b1, 32'h7FC00000, 1'b1, 1'b0};

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, ir32}, 64'd1);
    chk("rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("rst_out_y", {32'd0, y32}, 64'd0);
    chk("rst_flags", {62'd0, nv32, dz32}, 64'd0);
    chk("rst_fma_req", {63'd0, req32}, 64'd0);
    chk("rst_fma_abc", {a32, b32 | c32}, 64'd0);
    chk("rst_busy", {63'd0, busy32}, 64'd0);
    chk("rst64_outs", {60'd0, ir64, ov64, req64, busy64}, 64'h8);
    rst_n = 1'b1;

    // 4.0 with zero-wait FMA and 10 cycles of backpressure.
    run_op(1'b0, 64'h40800000, 10, y, nv, dz, lat, acks);
    chk("x4_req0_a", {32'd0, log_a[0]}, 64'h40800000);
    chk("x4_req0_b", {32'd0, log_b[0]}, 64'hBF000000);
    chk("x4_req0_c", {32'd0, log_c[0]}, 64'h0);
    chk("x4_seed_a", {32'd0, log_a[1]}, 64'h3EF759DF);
    chk("x4_seed_b", {32'd0, log_b[1]}, 64'h3EF759DF);
    chk("x4_madd_a", {32'd0, log_a[2]}, 64'hC0000000);
    chk("x4_madd_c", {32'd0, log_c[2]}, 64'h3FC00000);
    chk("x4_acks", acks, ACKS32);
    chk("x4_latency", lat, LAT32);
    chk_real("x4_y", f32_to_real(y[31:0]), f32_to_real(E_4), 1e-5);

    // Table of operands: normal values within tolerance, specials bit-exact with T+1 and no FMA use.
    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, {32'd0, vecs[i].x}, 0, y, nv, dz, lat, acks);
      if (vecs[i].sp) chk($sformatf("v%0d_y", i), y, {32'd0, vecs[i].y});
      else chk_real($sformatf("v%0d_y", i), f32_to_real(y[31:0]), f32_to_real(vecs[i].y), 1e-5);
      chk($sformatf("v%0d_nv", i), {63'd0, nv}, {63'd0, vecs[i].nv});
      chk($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].sp ? 1 : LAT32);
      chk($sformatf("v%0d_acks", i), acks, vecs[i].sp ? 0 : ACKS32);
    end

    // Each FMA wait cycle adds exactly one cycle.
    mode32 = 2;
    run_op(1'b0, 64'h40800000, 0, y, nv, dz, lat, acks);
    chk("wait3_latency", lat, LAT32 + 3 * ACKS32);
    chk_real("wait3_y", f32_to_real(y[31:0]), f32_to_real(E_4), 1e-5);

    // binary64, 2.0, random ack delays.
    mode64 = 1;
    run_op(1'b1, 64'h4000000000000000, 3, y, nv, dz, lat, acks);
    chk_real("x2_64_y", $bitstoreal(y), R64, 1e-9);
    chk("x2_64_acks", acks, ACKS64);
    chk("x2_64_flags", {62'd0, nv, dz}, 64'd0);

    // Reset in MADD: request drops at once, a late ack is ignored, next op is clean.
    mode32 = 2;
    @(negedge clk);
    iv32 = 1'b1; x32 = 32'h40800000;
    @(negedge clk);
    iv32 = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      #2;
      guard++;
    end while (!(req32 && c32 == 32'h3FC00000) && guard < 100);
    chk("madd_reached", {63'd0, req32}, 64'd1);
    en32 = 1'b0;
    ack32 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_fma_req", {63'd0, req32}, 64'd0);
    chk("arst_fma_abc", {a32, b32 | c32}, 64'd0);
    chk("arst_ready_busy", {62'd0, ir32, busy32}, 64'h2);
    chk("arst_out", {30'd0, ov32, nv32, y32}, 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    ack32 = 1'b1;
    res32 = 32'h12345678;
    @(posedge clk);
    #1;
    ack32 = 1'b0;
    chk("late_ack_ignored", {61'd0, busy32, ov32, req32}, 64'd0);
    mode32 = 0;
    en32 = 1'b1;
    run_op(1'b0, 64'h40800000, 0, y, nv, dz, lat, acks);
    chk_real("post_rst_y", f32_to_real(y[31:0]), f32_to_real(E_4), 1e-5);
    chk("post_rst_latency", lat, LAT32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end
endmodule
